bird_motion_ctrl: RTL and testbench

//  Parametrised bird controller: game-phase FSM plus vertical physics (gravity, flap impulse,

---
 rtl/bird_motion_ctrl_if.sv | 46 ++++
 rtl/bird_motion_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_bird_motion_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bird_motion_ctrl_if.sv
// ---------------------------------------------------------------------------
// bird_motion_ctrl_if
//   Bundles the signals between the game logic (key/collision side and
//   renderer) and the bird motion controller.
//
//   Parameters
//     Y_W  width of bird_y
//     V_W  width of the signed velocity bird_vy
//
//   Signals
//     start       game logic -> ctrl   level start/restart request
//     flap        game logic -> ctrl   raw flap key level
//     touched     game logic -> ctrl   pipe collision level
//     bird_y      ctrl -> game logic   current bird row (0 = top)
//     bird_vy     ctrl -> game logic   signed velocity, rows/frame
//     state       ctrl -> game logic   00 READY, 01 RUN, 10 DYING, 11 OVER
//     frame_tick  ctrl -> game logic   one-cycle frame pulse
//     game_over   ctrl -> game logic   high in OVER
//
//   Modports
//     master  the game logic side (drives requests, observes the bird)
//     slave   the motion controller
// ---------------------------------------------------------------------------
interface bird_motion_ctrl_if #(
    parameter int Y_W = 8,
    parameter int V_W = 6
);
    logic                  start;
    logic                  flap;
    logic                  touched;
    logic [Y_W-1:0]        bird_y;
    logic signed [V_W-1:0] bird_vy;
    logic [1:0]            state;
    logic                  frame_tick;
    logic                  game_over;

    modport master (
        output start, flap, touched,
        input  bird_y, bird_vy, state, frame_tick, game_over
    );

    modport slave (
        input  start, flap, touched,
        output bird_y, bird_vy, state, frame_tick, game_over
    );
endinterface

// File: rtl/bird_motion_ctrl.sv
// ---------------------------------------------------------------------------
// bird_motion_ctrl
//   Game-phase FSM plus vertical bird physics (gravity, flap impulse,
//   terminal velocity) advanced once per frame tick.
//
//   Ports
//     clk      clock
//     resetn   synchronous active-low reset
//     ctrl_if  bird_motion_ctrl_if.slave: start/flap/touched in,
//              bird_y/bird_vy/state/frame_tick/game_over out
//
//   Optional feature macro: CEIL_DEATH_EN
//     defined   : hitting the ceiling while running kills the bird (DYING)
//     undefined : the bird is clamped at row 0 and keeps running
// ---------------------------------------------------------------------------
module bird_motion_ctrl #(
    parameter int Y_W      = 8,
    parameter int V_W      = 6,
    parameter int Y_START  = 60,
    parameter int Y_MAX    = 119,
    parameter int GRAVITY  = 1,
    parameter int FLAP_V   = 6,
    parameter int V_MAX    = 8,
    parameter int TICK_DIV = 833333
) (
    input  logic              clk,
    input  logic              resetn,
    bird_motion_ctrl_if.slave ctrl_if
);

    typedef enum logic [1:0] {
        ST_READY = 2'b00,
        ST_RUN   = 2'b01,
        ST_DYING = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int S_W   = Y_W + 2;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [Y_W-1:0]        Y_INIT   = Y_W'(Y_START);
    localparam logic [Y_W-1:0]        Y_FLOOR  = Y_W'(Y_MAX);
    localparam logic signed [S_W-1:0] Y_FLOOR_S = S_W'(Y_MAX);
    localparam logic signed [V_W-1:0] VY_FLAP  = V_W'(-FLAP_V);
    localparam logic signed [V_W:0]   VMAX_EXT = (V_W + 1)'(V_MAX);
    localparam logic signed [V_W-1:0] VMAX_V   = V_W'(V_MAX);

    state_e                state_q, state_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic signed [V_W-1:0] vy_q, vy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic                  flap_dly_q;
    logic                  tick_q;
    logic                  game_over_q;

    logic                  flap_edge_s;
    logic signed [V_W:0]   vy_grav_s;
    logic signed [V_W-1:0] vy_sat_s;
    logic signed [V_W-1:0] vy_n_s;
    logic signed [S_W-1:0] sum_s;

    // Physics datapath: candidate velocity and position for this frame.
    always_comb begin
        flap_edge_s = ctrl_if.flap & ~flap_dly_q;
        // One extra bit so vy+GRAVITY cannot wrap before saturation.
        vy_grav_s   = {vy_q[V_W-1], vy_q} + (V_W + 1)'(GRAVITY);
        if (vy_grav_s > VMAX_EXT) begin
            vy_sat_s = VMAX_V;
        end else begin
            vy_sat_s = vy_grav_s[V_W-1:0];
        end
        // A flap edge arriving on the tick cycle still counts for this frame.
        if ((state_q == ST_RUN) && (pend_q || flap_edge_s)) begin
            vy_n_s = VY_FLAP;
        end else begin
            vy_n_s = vy_sat_s;
        end
        sum_s = $signed({2'b00, y_q}) + $signed({{(S_W - V_W){vy_n_s[V_W-1]}}, vy_n_s});
    end

    // Next-state logic: divider, game phase, flap latch and bird motion.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vy_d    = vy_q;
        pend_d  = pend_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_READY: begin
                y_d  = Y_INIT;
                vy_d = '0;
                if (ctrl_if.start || flap_edge_s) begin
                    state_d = ST_RUN;
                    pend_d  = 1'b1;
                end else begin
                    pend_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (ctrl_if.touched) begin
                    // Collision wins over any flap or ceiling event this cycle.
                    state_d = ST_DYING;
                    pend_d  = 1'b0;
                end else if (tick_q) begin
                    pend_d = 1'b0;
                    if (sum_s >= Y_FLOOR_S) begin
                        y_d     = Y_FLOOR;
                        vy_d    = '0;
                        state_d = ST_OVER;
                    end else if (sum_s[S_W-1]) begin
                        y_d  = '0;
                        vy_d = '0;
`ifdef CEIL_DEATH_EN
                        state_d = ST_DYING;
`else
                        state_d = ST_RUN;
`endif
                    end else begin
                        y_d  = sum_s[Y_W-1:0];
                        vy_d = vy_n_s;
                    end
                end else if (flap_edge_s) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
            end
            ST_DYING: begin
                pend_d = 1'b0;
                if (tick_q) begin
                    vy_d = vy_n_s;
                    if (sum_s >= Y_FLOOR_S) begin
                        y_d     = Y_FLOOR;
                        vy_d    = '0;
                        state_d = ST_OVER;
                    end else if (sum_s[S_W-1]) begin
                        y_d = '0;
                    end else begin
                        y_d = sum_s[Y_W-1:0];
                    end
                end else begin
                    vy_d = vy_q;
                end
            end
            ST_OVER: begin
                pend_d = 1'b0;
                if (ctrl_if.start) begin
                    state_d = ST_READY;
                    y_d     = Y_INIT;
                    vy_d    = '0;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_READY;
                y_d     = Y_INIT;
                vy_d    = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_READY;
            y_q         <= Y_INIT;
            vy_q        <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            flap_dly_q  <= 1'b0;
            tick_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            flap_dly_q  <= ctrl_if.flap;
            // Registered decode: high exactly while the divider sits at its last count.
            tick_q      <= (cnt_d == CNT_LAST);
            game_over_q <= (state_d == ST_OVER);
        end
    end

    assign ctrl_if.bird_y     = y_q;
    assign ctrl_if.bird_vy    = vy_q;
    assign ctrl_if.state      = state_q;
    assign ctrl_if.frame_tick = tick_q;
    assign ctrl_if.game_over  = game_over_q;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bird_motion_ctrl
//   Scoreboard bench for bird_motion_ctrl with TICK_DIV=4. The driver applies
//   one input vector per cycle, advances a frame-level behavioural model and
//   queues the expected outputs; a monitor pops one entry after every clock
//   edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_bird_motion_ctrl;

    localparam int TDIV = 4;
    localparam int YS   = 60;
    localparam int YM   = 119;
    localparam int GR   = 1;
    localparam int FV   = 6;
    localparam int VM   = 8;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] y;
        logic [5:0] vy;
        logic       tick;
        logic       go;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb_q[$];

    // Behavioural model state (plain integers, phase encoded 0..3).
    int m_phase, m_y, m_vy, m_cnt, m_pend, m_prev;

    bird_motion_ctrl_if #(.Y_W(8), .V_W(6)) bus ();

    bird_motion_ctrl #(
        .Y_W(8), .V_W(6), .Y_START(YS), .Y_MAX(YM), .GRAVITY(GR),
        .FLAP_V(FV), .V_MAX(VM), .TICK_DIV(TDIV)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .ctrl_if(bus)
    );

    always #5 clk = ~clk;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock edge of game behaviour, written from the game rules.
    task automatic model_step(input logic r, input logic s, input logic f, input logic t);
        int  nv, pos;
        bit  tick, edge_seen;
        if (!r) begin
            m_phase = 0; m_y = YS; m_vy = 0; m_cnt = 0; m_pend = 0; m_prev = 0;
            return;
        end
        tick      = (m_cnt == TDIV - 1);
        edge_seen = f && !m_prev;
        m_prev    = f;
        m_cnt     = (m_cnt + 1) % TDIV;
        case (m_phase)
            0: begin
                m_y = YS; m_vy = 0;
                if (s || edge_seen) begin m_phase = 1; m_pend = 1; end
            end
            1: begin
                if (t) begin
                    m_phase = 2; m_pend = 0;
                end else begin
                    if (edge_seen) m_pend = 1;
                    if (tick) begin
                        nv  = m_pend ? -FV : imin(m_vy + GR, VM);
                        pos = m_y + nv;
                        m_pend = 0;
                        if (pos >= YM) begin
                            m_y = YM; m_vy = 0; m_phase = 3;
                        end else if (pos < 0) begin
                            m_y = 0; m_vy = 0;
`ifdef CEIL_DEATH_EN
                            m_phase = 2;
`endif
                        end else begin
                            m_y = pos; m_vy = nv;
                        end
                    end
                end
            end
            2: begin
                m_pend = 0;
                if (tick) begin
                    nv  = imin(m_vy + GR, VM);
                    pos = m_y + nv;
                    if (pos >= YM) begin
                        m_y = YM; m_vy = 0; m_phase = 3;
                    end else begin
                        m_y = (pos < 0) ? 0 : pos; m_vy = nv;
                    end
                end
            end
            default: begin
                if (s) begin m_phase = 0; m_y = YS; m_vy = 0; end
            end
        endcase
    endtask

    // Apply one input vector, advance the model and queue the expectation.
    task automatic drive(input logic r, input logic s, input logic f, input logic t);
        exp_t e;
        int   vbits;
        @(negedge clk);
        resetn      = r;
        bus.start   = s;
        bus.flap    = f;
        bus.touched = t;
        model_step(r, s, f, t);
        vbits  = m_vy;
        e.st   = 2'(m_phase);
        e.y    = 8'(m_y);
        e.vy   = vbits[5:0];
        e.tick = (m_cnt == TDIV - 1);
        e.go   = (m_phase == 3);
        sb_q.push_back(e);
    endtask

    // Monitor: after every edge compare DUT outputs with the next expectation.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {bus.state, bus.bird_y, bus.bird_vy, bus.frame_tick, bus.game_over};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d: got st=%0d y=%0d vy=%0d tick=%0b go=%0b, expected st=%0d y=%0d vy=%0d tick=%0b go=%0b",
                             cyc, got.st, got.y, $signed(got.vy), got.tick, got.go,
                             e.st, e.y, $signed(e.vy), e.tick, e.go);
                end
            end
        end
    end

    // Stimulus: directed game scenarios followed by random play.
    initial begin
        logic fk;
        resetn = 1'b0; bus.start = 1'b0; bus.flap = 1'b0; bus.touched = 1'b0;
        m_phase = 0; m_y = YS; m_vy = 0; m_cnt = 0; m_pend = 0; m_prev = 0;

        // Reset then idle in READY.
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Flap in READY, key held (single flap), then free fall to the floor.
        repeat (14) drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (160) drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Start, collide after a few frames, flap while dying, fall to OVER.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (9) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 150; i++) drive(1'b1, 1'b0, (i % 4) < 2, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Flap every frame up to the ceiling.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 120; i++) drive(1'b1, 1'b0, (i % 4) < 2, 1'b0);
        repeat (160) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a run.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Random play.
        fk = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5, 0) == 0) fk = ~fk;
            drive(($urandom_range(699, 0) != 0),
                  ($urandom_range(39, 0) == 0),
                  fk,
                  ($urandom_range(149, 0) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
